serial_rx: RTL and testbench

Start/stop-framed serial receiver: oversamples an asynchronous idle-high line, detects a start bit, shifts in DATA_BITS data bits LSB-first, checks one stop bit, and presents each received word as a parallel output with a one-cycle valid strobe. It is the receive end of the team's shift-register serial transmitter and sits between an external pin and the parallel register logic. Framing errors are flagged and never delivered as data.

---
 rtl/serial_rx.sv | 159 +++++++++++++++
 tb/tb_serial_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Start/stop-framed serial receiver: two-flop synchronizer, mid-bit sampling,
// LSB-first shift-in, stop-bit check with one-cycle valid / frame_err strobes.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 0) ? $clog2(DATA_BITS + 1) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t               state_r, state_nx_s;
  logic                 s1_r, rx_sync_r;
  logic [CW-1:0]        cnt_r, cnt_nx_s;
  logic [IW-1:0]        idx_r, idx_nx_s;
  logic [DATA_BITS-1:0] sh_r, sh_nx_s;
  logic [DATA_BITS-1:0] data_r, data_nx_s;
  logic                 valid_r, valid_nx_s;
  logic                 ferr_r, ferr_nx_s;
  logic                 busy_r;

  // Shift right by one with the new bit entering the MSB (LSB-first framing).
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] cur,
                                                    input logic bit_in);
    logic [DATA_BITS-1:0] res;
    for (int i = 0; i < DATA_BITS - 1; i++) begin
      res[i] = cur[i+1];
    end
    res[DATA_BITS-1] = bit_in;
    return res;
  endfunction

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    sh_nx_s    = sh_r;
    data_nx_s  = data_r;
    valid_nx_s = 1'b0;
    ferr_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_nx_s = ST_START;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_nx_s = {CW{1'b0}};
          if (!rx_sync_r) begin
            state_nx_s = ST_DATA;
            idx_nx_s   = {IW{1'b0}};
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_FULL) begin
          cnt_nx_s = {CW{1'b0}};
          sh_nx_s  = shift_in(sh_r, rx_sync_r);
          idx_nx_s = idx_r + IW'(1);
          if (idx_r == IDX_LAST) begin
            state_nx_s = ST_STOP;
          end else begin
            state_nx_s = ST_DATA;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_STOP: begin
        // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
        if (cnt_r == CNT_FULL) begin
          cnt_nx_s = {CW{1'b0}};
          if (rx_sync_r) begin
            data_nx_s  = sh_r;
            valid_nx_s = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            ferr_nx_s  = 1'b1;
            state_nx_s = ST_BREAK;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_BREAK: begin
        if (rx_sync_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BREAK;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {CW{1'b0}};
        idx_nx_s   = {IW{1'b0}};
      end
    endcase
  end

  // State, datapath, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_r      <= 1'b1;
      rx_sync_r <= 1'b1;
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      idx_r     <= {IW{1'b0}};
      sh_r      <= {DATA_BITS{1'b0}};
      data_r    <= {DATA_BITS{1'b0}};
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      s1_r      <= rx;
      rx_sync_r <= s1_r;
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      idx_r     <= idx_nx_s;
      sh_r      <= sh_nx_s;
      data_r    <= data_nx_s;
      valid_r   <= valid_nx_s;
      ferr_r    <= ferr_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: default instance (16 clk/bit, 8 bits) and a
// small instance (4 clk/bit, 5 bits); pulses are timed against a cycle counter.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a;
  logic       valid_a, ferr_a, busy_a;
  logic [4:0] data_b;
  logic       valid_b, ferr_b, busy_b;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int va_cnt = 0, va_cyc = 0, va_prev = 0;
  int fa_cnt = 0, fa_cyc = 0;
  int vb_cnt = 0, vb_cyc = 0;
  int fb_cnt = 0;
  int both_cnt = 0;

  serial_rx u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a),
    .data(data_a), .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
  );

  serial_rx #(.CLKS_PER_BIT(4), .DATA_BITS(5)) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b),
    .data(data_b), .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_a) begin
      va_cnt  <= va_cnt + 1;
      va_prev <= va_cyc;
      va_cyc  <= cyc;
    end
    if (ferr_a) begin
      fa_cnt <= fa_cnt + 1;
      fa_cyc <= cyc;
    end
    if (valid_b) begin
      vb_cnt <= vb_cnt + 1;
      vb_cyc <= cyc;
    end
    if (ferr_b) fb_cnt <= fb_cnt + 1;
    if ((valid_a && ferr_a) || (valid_b && ferr_b)) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Drives one frame; called #1 after a rising edge, returns likewise.
  task automatic send_frame(input bit sel, input logic [15:0] word, input int nbits,
                            input int cpb, input logic stop_val, input int stop_len,
                            output int fall);
    fall = cyc;
    drive(sel, 1'b0);
    wait_cyc(cpb);
    check_eq("busy_mid_frame", {31'd0, (sel ? busy_b : busy_a)}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, word[i]);
      wait_cyc(cpb);
    end
    drive(sel, stop_val);
    wait_cyc(stop_len);
  endtask

  int f0, f1, v0, e0, t0;

  initial begin
    wait_cyc(4);
    check_eq("rst_data", {24'd0, data_a}, 32'h0);
    check_eq("rst_valid", {31'd0, valid_a}, 32'd0);
    check_eq("rst_ferr", {31'd0, ferr_a}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    reset = 1'b1;
    wait_cyc(10);

    // Frame 0xA5
    v0 = va_cnt; e0 = fa_cnt;
    send_frame(1'b0, 16'h00A5, 8, 16, 1'b1, 16, f0);
    wait_cyc(4);
    check_eq("a5_valid_cnt", va_cnt - v0, 32'd1);
    check_eq("a5_valid_cyc", va_cyc - f0, 32'd155);
    check_eq("a5_data", {24'd0, data_a}, 32'hA5);
    check_eq("a5_ferr_cnt", fa_cnt - e0, 32'd0);
    check_eq("a5_busy_after", {31'd0, busy_a}, 32'd0);

    // 3-cycle glitch
    v0 = va_cnt; e0 = fa_cnt;
    rx_a = 1'b0;
    wait_cyc(3);
    rx_a = 1'b1;
    wait_cyc(2);
    check_eq("glitch_busy_high", {31'd0, busy_a}, 32'd1);
    wait_cyc(7);
    check_eq("glitch_busy_low", {31'd0, busy_a}, 32'd0);
    wait_cyc(20);
    check_eq("glitch_valid_cnt", va_cnt - v0, 32'd0);
    check_eq("glitch_ferr_cnt", fa_cnt - e0, 32'd0);
    check_eq("glitch_data", {24'd0, data_a}, 32'hA5);

    // Frame 0x3C with bad stop, line low 40 cycles
    v0 = va_cnt; e0 = fa_cnt;
    send_frame(1'b0, 16'h003C, 8, 16, 1'b0, 40, f0);
    check_eq("brk_busy_held", {31'd0, busy_a}, 32'd1);
    check_eq("brk_ferr_cnt", fa_cnt - e0, 32'd1);
    check_eq("brk_ferr_cyc", fa_cyc - f0, 32'd155);
    check_eq("brk_valid_cnt", va_cnt - v0, 32'd0);
    check_eq("brk_data_kept", {24'd0, data_a}, 32'hA5);
    rx_a = 1'b1;
    wait_cyc(5);
    check_eq("brk_busy_low", {31'd0, busy_a}, 32'd0);
    v0 = va_cnt;
    send_frame(1'b0, 16'h005A, 8, 16, 1'b1, 20, f0);
    check_eq("5a_data", {24'd0, data_a}, 32'h5A);
    check_eq("5a_valid_cnt", va_cnt - v0, 32'd1);

    // Back-to-back 0x00 then 0xFF
    v0 = va_cnt;
    send_frame(1'b0, 16'h0000, 8, 16, 1'b1, 16, f0);
    check_eq("b2b_data0", {24'd0, data_a}, 32'h00);
    send_frame(1'b0, 16'h00FF, 8, 16, 1'b1, 16, f1);
    wait_cyc(4);
    check_eq("b2b_data1", {24'd0, data_a}, 32'hFF);
    check_eq("b2b_valid_cnt", va_cnt - v0, 32'd2);
    check_eq("b2b_spacing", va_cyc - va_prev, 32'd160);
    check_eq("b2b_first_cyc", va_prev - f0, 32'd155);

    // Reset during data bit 4 of 0xC3
    wait_cyc(10);
    rx_a = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 4; i++) begin
      rx_a = (8'hC3 >> i) & 8'h01;
      wait_cyc(16);
    end
    rx_a = 1'b0;
    wait_cyc(8);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    check_eq("abort_data", {24'd0, data_a}, 32'h0);
    check_eq("abort_valid", {31'd0, valid_a}, 32'd0);
    check_eq("abort_ferr", {31'd0, ferr_a}, 32'd0);
    check_eq("abort_busy", {31'd0, busy_a}, 32'd0);
    v0 = va_cnt; e0 = fa_cnt;
    wait_cyc(7);
    for (int i = 5; i < 8; i++) begin
      rx_a = (8'hC3 >> i) & 8'h01;
      wait_cyc(16);
    end
    rx_a = 1'b1;
    wait_cyc(16);
    check_eq("abort_tail_valid", va_cnt - v0, 32'd0);
    check_eq("abort_tail_ferr", fa_cnt - e0, 32'd0);
    // Let the receiver settle before the next real frame.
    wait_cyc(250);
    v0 = va_cnt;
    send_frame(1'b0, 16'h0081, 8, 16, 1'b1, 20, f0);
    check_eq("post_abort_data", {24'd0, data_a}, 32'h81);
    check_eq("post_abort_valid_cnt", va_cnt - v0, 32'd1);
    check_eq("post_abort_valid_cyc", va_cyc - f0, 32'd155);

    // Small instance: 4 clk/bit, 5 bits, 0x15
    t0 = vb_cnt;
    send_frame(1'b1, 16'h0015, 5, 4, 1'b1, 8, f0);
    check_eq("small_data", {27'd0, data_b}, 32'h15);
    check_eq("small_valid_cnt", vb_cnt - t0, 32'd1);
    check_eq("small_valid_cyc", vb_cyc - f0, 32'd29);
    check_eq("small_ferr_cnt", fb_cnt, 32'd0);

    check_eq("valid_ferr_overlap", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
